rr_reg_arbiter: RTL and testbench

- Round-robin arbiter that shares one DATA_W-bit capture register (a bank of D flip-flops) between N_REQ requesters.
- Each cycle it may grant one requester and load that requester's data into the shared register. It reports who owns the value.
- After each grant, an optional hold window keeps the register stable for HOLD_CYC cycles before the next grant.

---
 rtl/rr_reg_arbiter_if.sv | 26 ++
 rtl/rr_reg_arbiter.sv | 142 ++++++++++++++
 tb/tb_rr_reg_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rr_reg_arbiter_if.sv
// Requester-side bundle for the shared-register round-robin arbiter.
// Master drives req/wdata; slave (the arbiter) returns grant and register state.
interface rr_reg_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int OWN_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [DATA_W-1:0]       q;
    logic                    q_valid;
    logic [OWN_W-1:0]        q_owner;
    logic                    busy;

    modport master (
        output req, wdata,
        input  gnt, q, q_valid, q_owner, busy
    );

    modport slave (
        input  req, wdata,
        output gnt, q, q_valid, q_owner, busy
    );
endinterface

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one capture register between N_REQ requesters.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no pointer).
module rr_reg_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int HOLD_CYC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_reg_arbiter_if.slave bus
);
    localparam int OWN_W = $clog2(N_REQ);
    localparam int SUM_W = OWN_W + 1;
    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [DATA_W-1:0]  q_q, q_d;
    logic [OWN_W-1:0]   own_q, own_d;
    logic               vld_q, vld_d;
    logic               busy_q, busy_d;
    logic [OWN_W-1:0]   base;
    logic               win_vld;
    logic [OWN_W-1:0]   win_idx;
    logic [SUM_W-1:0]   cand;

`ifdef ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [OWN_W-1:0]   ptr_q, ptr_d;
    assign base = ptr_q;
`endif

    // Rotating search for the first pending requester starting at base.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, base} + SUM_W'(k);
            if (cand >= SUM_W'(N_REQ)) begin
                cand = cand - SUM_W'(N_REQ);
            end
            if (!win_vld && bus.req[cand[OWN_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[OWN_W-1:0];
            end
        end
    end

    // Next state: grant and capture in IDLE, count down the hold window.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        q_d     = q_q;
        own_d   = own_q;
        vld_d   = vld_q;
        busy_d  = busy_q;
`ifndef ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gnt_d[win_idx] = 1'b1;
                    q_d   = bus.wdata[win_idx*DATA_W +: DATA_W];
                    own_d = win_idx;
                    vld_d = 1'b1;
`ifndef ARB_FIXED_PRIO_EN
                    if (win_idx == OWN_W'(N_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_idx + OWN_W'(1);
                    end
`endif
                    if (HOLD_CYC > 0) begin
                        cnt_d   = CNT_W'(HOLD_CYC - 1);
                        state_d = HOLD;
                        busy_d  = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            q_q     <= '0;
            own_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            own_q   <= own_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    // Round-robin pointer, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign bus.gnt     = gnt_q;
    assign bus.q       = q_q;
    assign bus.q_valid = vld_q;
    assign bus.q_owner = own_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed bench for rr_reg_arbiter with hold windows of 0, 2 and 3 cycles.
// Expected values are hand-computed; fixed-priority values apply under ARB_FIXED_PRIO_EN.
module tb_rr_reg_arbiter;
    logic clk = 1'b0;
    logic rst0, rst2, rst3;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rr_reg_arbiter_if #(.N_REQ(4), .DATA_W(8)) if0 ();
    rr_reg_arbiter_if #(.N_REQ(4), .DATA_W(8)) if2 ();
    rr_reg_arbiter_if #(.N_REQ(4), .DATA_W(8)) if3 ();

    rr_reg_arbiter #(.N_REQ(4), .DATA_W(8), .HOLD_CYC(0)) dut0 (
        .clk(clk), .rst_n(rst0), .bus(if0)
    );
    rr_reg_arbiter #(.N_REQ(4), .DATA_W(8), .HOLD_CYC(2)) dut2 (
        .clk(clk), .rst_n(rst2), .bus(if2)
    );
    rr_reg_arbiter #(.N_REQ(4), .DATA_W(8), .HOLD_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst3), .bus(if3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] eg [5];
        logic [7:0] eq [5];
        logic [1:0] eo [5];

        rst0 = 1'b0;
        rst2 = 1'b0;
        rst3 = 1'b0;
        if0.req = 4'b1111;
        if0.wdata = {8'h43, 8'h32, 8'h21, 8'h10};
        if2.req = 4'b0000;
        if2.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        if3.req = 4'b0000;
        if3.wdata = {8'hD4, 8'hC3, 8'hB2, 8'hA1};

        // Reset held with requests pending and clock running
        step();
        step();
        chk("rst_gnt", 32'(if0.gnt), 32'h0);
        chk("rst_q", 32'(if0.q), 32'h00);
        chk("rst_vld", 32'(if0.q_valid), 32'h0);
        chk("rst_busy", 32'(if0.busy), 32'h0);
        chk("rst_own", 32'(if0.q_owner), 32'h0);
        rst0 = 1'b1;
        rst2 = 1'b1;
        rst3 = 1'b1;

        // Back-to-back rotation with all four requesting
`ifdef ARB_FIXED_PRIO_EN
        eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        eq = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
        eo = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        eq = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
        eo = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rot_gnt%0d", i), 32'(if0.gnt), 32'(eg[i]));
            chk($sformatf("rot_q%0d", i), 32'(if0.q), 32'(eq[i]));
            chk($sformatf("rot_own%0d", i), 32'(if0.q_owner), 32'(eo[i]));
        end
        chk("rot_vld", 32'(if0.q_valid), 32'h1);

        // Asynchronous reset between edges clears outputs at once
        rst0 = 1'b0;
        #2;
        chk("arst_gnt", 32'(if0.gnt), 32'h0);
        chk("arst_q", 32'(if0.q), 32'h00);
        chk("arst_vld", 32'(if0.q_valid), 32'h0);
        rst0 = 1'b1;

        // Single requester re-granted every cycle, then drops
        if0.req = 4'b1000;
        if0.wdata = {8'hA5, 8'h32, 8'h21, 8'h10};
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("solo_gnt%0d", i), 32'(if0.gnt), 32'h8);
            chk($sformatf("solo_q%0d", i), 32'(if0.q), 32'hA5);
            chk($sformatf("solo_own%0d", i), 32'(if0.q_owner), 32'h3);
        end
        if0.req = 4'b0000;
        step();
        chk("drop_gnt", 32'(if0.gnt), 32'h0);
        chk("drop_q", 32'(if0.q), 32'hA5);
        chk("drop_vld", 32'(if0.q_valid), 32'h1);
        chk("drop_own", 32'(if0.q_owner), 32'h3);

        // Two requesters with a two-cycle hold window
        if2.req = 4'b0101;
        step();
        chk("h2_g0", 32'(if2.gnt), 32'h1);
        chk("h2_q0", 32'(if2.q), 32'h11);
        chk("h2_b0", 32'(if2.busy), 32'h1);
        step();
        chk("h2_g1", 32'(if2.gnt), 32'h0);
        chk("h2_b1", 32'(if2.busy), 32'h1);
        chk("h2_q1", 32'(if2.q), 32'h11);
        step();
        chk("h2_g2", 32'(if2.gnt), 32'h0);
        chk("h2_b2", 32'(if2.busy), 32'h0);
        chk("h2_q2", 32'(if2.q), 32'h11);
        step();
`ifdef ARB_FIXED_PRIO_EN
        chk("h2_g3", 32'(if2.gnt), 32'h1);
        chk("h2_o3", 32'(if2.q_owner), 32'h0);
`else
        chk("h2_g3", 32'(if2.gnt), 32'h4);
        chk("h2_o3", 32'(if2.q_owner), 32'h2);
        chk("h2_q3", 32'(if2.q), 32'h33);
`endif
        chk("h2_b3", 32'(if2.busy), 32'h1);
        step();
        chk("h2_g4", 32'(if2.gnt), 32'h0);
        step();
        chk("h2_g5", 32'(if2.gnt), 32'h0);
        chk("h2_b5", 32'(if2.busy), 32'h0);
        step();
        chk("h2_g6", 32'(if2.gnt), 32'h1);
        chk("h2_o6", 32'(if2.q_owner), 32'h0);
        if2.req = 4'b0000;

        // Reset lands in the middle of a three-cycle hold
        if3.req = 4'b0010;
        step();
        chk("h3_g0", 32'(if3.gnt), 32'h2);
        chk("h3_q0", 32'(if3.q), 32'hB2);
        chk("h3_b0", 32'(if3.busy), 32'h1);
        if3.req = 4'b0000;
        step();
        chk("h3_b1", 32'(if3.busy), 32'h1);
        #2;
        rst3 = 1'b0;
        #1;
        chk("h3_rst_b", 32'(if3.busy), 32'h0);
        chk("h3_rst_g", 32'(if3.gnt), 32'h0);
        chk("h3_rst_q", 32'(if3.q), 32'h00);
        chk("h3_rst_v", 32'(if3.q_valid), 32'h0);
        rst3 = 1'b1;
        if3.req = 4'b0011;
        step();
        chk("h3_g1", 32'(if3.gnt), 32'h1);
        chk("h3_o1", 32'(if3.q_owner), 32'h0);
        chk("h3_q1", 32'(if3.q), 32'hA1);
        chk("h3_b2", 32'(if3.busy), 32'h1);
        if3.req = 4'b0000;

        // Priority order with the lowest requester absent
        if0.req = 4'b1110;
        step();
        chk("pr_g0", 32'(if0.gnt), 32'h2);
        step();
`ifdef ARB_FIXED_PRIO_EN
        chk("pr_g1", 32'(if0.gnt), 32'h2);
`else
        chk("pr_g1", 32'(if0.gnt), 32'h4);
`endif
        if0.req = 4'b1100;
        step();
`ifdef ARB_FIXED_PRIO_EN
        chk("pr_g2", 32'(if0.gnt), 32'h4);
`else
        chk("pr_g2", 32'(if0.gnt), 32'h8);
`endif
        if0.req = 4'b0000;
        step();
        chk("pr_idle", 32'(if0.gnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
